mem_dump_unit: RTL and testbench
================================

// Module: mem_dump_unit
// PURPOSE
//  Reads a contiguous window of the CPU's byte memory and streams it out as a valid/ready byte stream.
//  It is the read-back counterpart of program loading: it dumps results or memory images after a run.
//  It sits beside cpu_top on the memory read port and holds the CPU halted while it owns that port.
// PARAMETERS
//  ADDR_BITS  8  memory address width; addresses wrap modulo 2**ADDR_BITS
//  DATA_BITS  8  memory word / stream byte width
// PORTS
//  clk          input   1            system clock; all state changes on posedge
//  reset        input   1            asynchronous, active-low (0 = reset)
//  start        input   1            request a dump; sampled only in IDLE
//  start_addr   input   ADDR_BITS    first address to read; sampled with start
//  length       input   ADDR_BITS+1  byte count, 0..2**ADDR_BITS; sampled with start
//  busy         output  1            high in every state except IDLE
//  done         output  1            one-cycle pulse when the dump completes
//  cpu_halt     output  1            high while busy; the CPU must not access memory
//  mem_rd_en    output  1            memory read strobe
//  mem_addr     output  ADDR_BITS    memory read address
//  mem_rd_data  input   DATA_BITS    read data, valid the cycle after mem_rd_en is high
//  out_valid    output  1            stream byte valid
//  out_data     output  DATA_BITS    stream byte
//  out_last     output  1            qualifies the final byte of the dump (valid with out_valid)
//  out_ready    input   1            sink accepts the byte when out_valid && out_ready at posedge
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; all outputs 0; address and remaining-count registers 0.
//  FSM states: IDLE, READ, CAPTURE, SEND, DONE.
//  IDLE    -> start==1 && length!=0:
//             - latch addr=start_addr and remaining=length
//             - go to READ
//          -> start==1 && length==0: go to DONE; no mem read and no stream byte.
//          -> otherwise stay in IDLE.
//  READ    - mem_rd_en=1, mem_addr=addr, for exactly one cycle
//          -> CAPTURE
//  CAPTURE - register mem_rd_data into out_data
//          - out_last = (remaining==1)
//          -> SEND
//  SEND    - out_valid=1; out_data and out_last are held stable until the handshake
//          -> out_ready==1 && remaining==1: go to DONE.
//          -> out_ready==1 && remaining>1: addr=addr+1 (wrap), remaining-=1, go to READ.
//          -> out_ready==0: stay in SEND (any number of cycles).
//  DONE    - done=1 for one cycle
//          -> IDLE
//  Output timing and qualifiers:
//   - busy and cpu_halt are registered; high from the cycle after start is accepted through DONE inclusive.
//   - mem_rd_en is low outside READ.
//   - out_valid and out_last are low outside SEND.
//   - mem_addr holds its last value when idle.
//  Latency: start sampled at edge E -> READ in cycle E+1, first out_valid in cycle E+3.
//  Throughput: with out_ready tied high, one byte every 3 cycles.
//  start is ignored while busy (including in DONE); a new dump may start in the cycle after DONE.
//  Address 2**ADDR_BITS-1 is followed by address 0. length=2**ADDR_BITS dumps the whole memory exactly once.
//  Reset asserted mid-dump aborts immediately: no done pulse; cpu_halt drops asynchronously.
// TESTING
//  1. mem[0x10..0x13]=A1,B2,C3,D4; start_addr=0x10, length=4; out_ready=1
//     -> bytes A1,B2,C3,D4 at cycles E+3,+6,+9,+12
//     -> out_last only on D4; done one cycle after D4; cpu_halt high throughout.
//  2. Same dump; out_ready low for 5 cycles on the 2nd byte
//     -> B2 and out_last=0 held stable while stalled; no extra mem_rd_en; order preserved.
//  3. length=0 -> DONE the next cycle, done pulse, no mem_rd_en, no out_valid.
//  4. start_addr=0xFE, length=4 -> mem_addr sequence FE,FF,00,01; 4 bytes out; out_last on the 4th.
//  5. length=256, start_addr=0x00 -> 256 bytes matching mem[0..255]; exactly one out_last; one done.
//  6. Reset low during 3rd SEND -> all outputs 0 at once; no done. start re-pulsed while busy is ignored.

Source files
------------

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: streams a contiguous window of byte memory out as a
// valid/ready byte stream, holding the CPU halted while it owns the read port.
// Each byte takes READ (issue strobe), CAPTURE (latch read data) and SEND
// (hold until accepted), so an always-ready sink sees one byte every 3 cycles.
module mem_dump_unit #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_halt,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr, addr_nxt;
  logic [ADDR_BITS:0]   remaining, remaining_nxt;
  logic [DATA_BITS-1:0] data_q;
  logic                 last_q;
  logic                 busy_q;

  // Next-state logic: address and count advance only on an accepted byte.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_nxt      = start_addr;
            remaining_nxt = length;
            state_nxt     = READ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND: begin
        if (out_ready) begin
          if (remaining == (ADDR_BITS+1)'(1)) begin
            state_nxt = DONE;
          end else begin
            addr_nxt      = addr + ADDR_BITS'(1);
            remaining_nxt = remaining - (ADDR_BITS+1)'(1);
            state_nxt     = READ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, address, count and the busy flag; reset aborts a dump at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  // Capture the read byte and its last-flag; both stay stable through SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      last_q <= 1'b0;
    end else if (state == CAPTURE) begin
      data_q <= mem_rd_data;
      last_q <= (remaining == (ADDR_BITS+1)'(1));
    end
  end

  assign busy      = busy_q;
  assign cpu_halt  = busy_q;
  assign done      = (state == DONE);
  assign mem_rd_en = (state == READ);
  assign mem_addr  = addr;
  assign out_valid = (state == SEND);
  assign out_data  = data_q;
  assign out_last  = last_q && (state == SEND);

endmodule

// File: tb/tb_mem_dump_unit.sv
// tb_mem_dump_unit: directed bench for mem_dump_unit with a synchronous
// byte memory model, a vector table of dumps and hand-written corner cases.
module tb_mem_dump_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [8:0] length = '0;
  logic       busy, done, cpu_halt, mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data = '0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;

  logic [7:0] mem [256];

  int tests = 0;
  int fails = 0;

  logic [7:0] byte_q[$];
  logic       lastf_q[$];
  logic [7:0] addr_q[$];
  int         vcyc_q[$];
  int         rd_cnt, done_cnt, done_cyc;
  logic       halt_ok, stall_ok, timeout, post_busy, post_done;
  logic [7:0] post_addr;

  typedef struct packed {
    logic [7:0]      sa;
    logic [8:0]      len;
    logic [3:0][7:0] exp_b;
    logic [3:0][7:0] exp_a;
  } vec_t;

  vec_t vecs [4];

  mem_dump_unit #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .cpu_halt(cpu_halt),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input logic [7:0] sa, input logic [8:0] len,
                          input int stall_idx, input int stall_n, input int bound);
    int cyc;
    int stalled;
    logic [7:0] held_d;
    logic held_l;
    logic seen_done;
    byte_q.delete(); lastf_q.delete(); addr_q.delete(); vcyc_q.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1;
    halt_ok = 1'b1; stall_ok = 1'b1; timeout = 1'b0;
    held_d = '0; held_l = 1'b0;
    start_addr = sa; length = len; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; stalled = 0; seen_done = 1'b0;
    while (!seen_done && cyc <= bound) begin
      if (mem_rd_en) begin addr_q.push_back(mem_addr); rd_cnt++; end
      if (!busy || !cpu_halt) halt_ok = 1'b0;
      out_ready = 1'b1;
      if (out_valid) begin
        if (byte_q.size() == stall_idx && stalled < stall_n) begin
          if (stalled == 0) begin held_d = out_data; held_l = out_last; end
          else if (out_data !== held_d || out_last !== held_l) stall_ok = 1'b0;
          stalled++;
          out_ready = 1'b0;
        end else begin
          if (stalled > 0 && byte_q.size() == stall_idx &&
              (out_data !== held_d || out_last !== held_l)) stall_ok = 1'b0;
          byte_q.push_back(out_data);
          lastf_q.push_back(out_last);
          vcyc_q.push_back(cyc);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; seen_done = 1'b1; end
      tick();
      cyc++;
    end
    if (!seen_done) timeout = 1'b1;
    post_busy = busy; post_done = done; post_addr = mem_addr;
  endtask

  initial begin
    int nlast;
    int nbad;
    logic [31:0] act;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;

    vecs[0] = '{8'h10, 9'd4, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, {8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[1] = '{8'hFE, 9'd4, {8'h44, 8'h33, 8'h22, 8'h11}, {8'h01, 8'h00, 8'hFF, 8'hFE}};
    vecs[2] = '{8'h12, 9'd1, {8'h00, 8'h00, 8'h00, 8'hC3}, {8'h00, 8'h00, 8'h00, 8'h12}};
    vecs[3] = '{8'hFF, 9'd2, {8'h00, 8'h00, 8'h33, 8'h22}, {8'h00, 8'h00, 8'h00, 8'hFF}};

    // Reset state
    #2;
    check("rst_outs", {busy, done, cpu_halt, mem_rd_en, out_valid, out_last}, 6'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_data", out_data, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // Table-driven dumps with an always-ready sink
    for (int v = 0; v < 4; v++) begin
      run_dump(vecs[v].sa, vecs[v].len, -1, 0, 200);
      check($sformatf("v%0d_timeout", v), timeout, 1'b0);
      check($sformatf("v%0d_nbytes", v), byte_q.size(), 32'(vecs[v].len));
      check($sformatf("v%0d_nreads", v), rd_cnt, 32'(vecs[v].len));
      nlast = 0;
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        act = (i < byte_q.size()) ? 32'(byte_q[i]) : 32'hDEAD;
        check($sformatf("v%0d_byte%0d", v, i), act, 32'(vecs[v].exp_b[i]));
        act = (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hDEAD;
        check($sformatf("v%0d_addr%0d", v, i), act, 32'(vecs[v].exp_a[i]));
        act = (i < vcyc_q.size()) ? 32'(vcyc_q[i]) : 32'hDEAD;
        check($sformatf("v%0d_cyc%0d", v, i), act, 32'(3 + 3 * i));
      end
      foreach (lastf_q[i]) if (lastf_q[i]) nlast++;
      check($sformatf("v%0d_nlast", v), nlast, 1);
      act = (lastf_q.size() > 0) ? 32'(lastf_q[lastf_q.size()-1]) : 32'hDEAD;
      check($sformatf("v%0d_last_pos", v), act, 1);
      check($sformatf("v%0d_ndone", v), done_cnt, 1);
      check($sformatf("v%0d_done_cyc", v), done_cyc, 32'(3 * int'(vecs[v].len) + 1));
      check($sformatf("v%0d_halt", v), halt_ok, 1'b1);
      check($sformatf("v%0d_post", v), {post_busy, post_done}, 2'b00);
      check($sformatf("v%0d_addr_hold", v), post_addr,
            32'(vecs[v].exp_a[int'(vecs[v].len) - 1]));
      tick();
    end

    // Back-pressure: 2nd byte stalled for 5 cycles
    run_dump(8'h10, 9'd4, 1, 5, 200);
    check("stall_timeout", timeout, 1'b0);
    check("stall_held", stall_ok, 1'b1);
    check("stall_nreads", rd_cnt, 4);
    check("stall_nbytes", byte_q.size(), 4);
    act = (byte_q.size() == 4) ? {byte_q[0], byte_q[1], byte_q[2], byte_q[3]} : 32'hDEAD;
    check("stall_order", act, 32'hA1B2C3D4);
    act = (vcyc_q.size() == 4) ? 32'(vcyc_q[1]) : 32'hDEAD;
    check("stall_b2_cyc", act, 11);
    check("stall_done_cyc", done_cyc, 18);
    tick();

    // Zero-length dump
    run_dump(8'h40, 9'd0, -1, 0, 20);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_ndone", done_cnt, 1);
    check("zero_reads", rd_cnt, 0);
    check("zero_bytes", byte_q.size(), 0);
    check("zero_post", post_busy, 1'b0);
    tick();

    // Whole memory
    run_dump(8'h00, 9'd256, -1, 0, 1000);
    check("full_nbytes", byte_q.size(), 256);
    nbad = 0; nlast = 0;
    foreach (byte_q[i]) if (byte_q[i] !== mem[i]) nbad++;
    foreach (lastf_q[i]) if (lastf_q[i]) nlast++;
    check("full_bytes", nbad, 0);
    check("full_nlast", nlast, 1);
    check("full_ndone", done_cnt, 1);
    check("full_done_cyc", done_cyc, 769);
    tick();

    // start held high: ignored in DONE, taken again from IDLE
    start_addr = 8'h12; length = 9'd1; start = 1'b1; out_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    check("hold_done", done, 1'b1);
    tick();
    check("hold_idle", busy, 1'b0);
    tick();
    start = 1'b0;
    check("hold_restart", mem_rd_en, 1'b1);
    nbad = 1;
    for (int c = 0; c < 10 && nbad != 0; c++) begin
      if (done) nbad = 0;
      tick();
    end
    check("hold_finish", nbad, 0);
    tick();

    // Abort by reset during the 3rd SEND; start re-pulsed while busy
    start_addr = 8'h10; length = 9'd4; start = 1'b1;
    tick();
    start_addr = 8'h80; length = 9'd1;
    tick(); tick(); tick();
    check("busy_ign_addr", {mem_rd_en, mem_addr}, {1'b1, 8'h11});
    start = 1'b0;
    tick(); tick();
    check("busy_ign_byte", {out_valid, out_data}, {1'b1, 8'hB2});
    tick(); tick(); tick();
    check("abort_pre", {out_valid, out_data}, {1'b1, 8'hC3});
    reset = 1'b0;
    #1;
    check("abort_flags", {busy, done, cpu_halt, mem_rd_en, out_valid, out_last}, 6'b0);
    check("abort_bus", {mem_addr, out_data}, 16'h0000);
    tick();
    reset = 1'b1;
    nbad = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) nbad++;
      tick();
    end
    check("abort_no_done", nbad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
